dmem_wbuf_ctrl: RTL

DMEM_WBUF_CTRL -- requirements
Module: dmem_wbuf_ctrl

---
 rtl/dmem_wbuf_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_wbuf_ctrl.sv
// Data-memory front end: posted-store write buffer with load forwarding and a single-master bus FSM.
// Latency: buffered stores and forwarded loads complete in the access cycle; a load miss returns data the cycle after the bus ack.
// Backpressure: stall is raised while a store finds the buffer full or a load miss waits for drain + bus read; the bus is held until bus_ack.
module dmem_wbuf_ctrl #(
  parameter int WBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        stall,
  output logic        align_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;

  state_t          state_q, state_nx;
  logic [29:0]     wb_addr [WBUF_DEPTH];
  logic [31:0]     wb_data [WBUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, fwd_idx;
  logic [CW-1:0]   count;
  logic [31:0]     rd_data_q;
  logic [31:0]     fwd_data;
  logic            fwd_hit;
  logic            aligned, is_store, is_load, misalign, full;
  logic            enq, deq, load_miss;

  // Access decode; a simultaneous read+write request is a store.
  assign aligned   = (memaddr[1:0] == 2'b00);
  assign is_store  = memwrite;
  assign is_load   = memread & ~memwrite;
  assign misalign  = (memwrite | memread) & ~aligned;
  assign full      = (count == CW'(WBUF_DEPTH));
  assign enq       = is_store & aligned & ~full;
  assign deq       = (state_q == WR) & bus_ack;
  assign load_miss = is_load & aligned & ~fwd_hit;

  // Forwarding search from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      fwd_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (wb_addr[fwd_idx] == memaddr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[fwd_idx];
      end
    end
  end

  // Core-facing outputs; everything quiet while reset is asserted.
  always_comb begin
    stall       = 1'b0;
    memreaddata = '0;
    align_err   = 1'b0;
    if (reset) begin
      align_err   = misalign;
      memreaddata = fwd_hit && is_load ? fwd_data : rd_data_q;
      if (is_store && aligned)
        stall = full;
      else if (load_miss)
        stall = (state_q != RD_DONE);
    end
  end

  // Buffer storage; contents are meaningless while count says the slot is empty, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr[wr_ptr] <= memaddr[31:2];
      wb_data[wr_ptr] <= memwritedata;
    end
  end

  // Pointers and occupancy; enqueue and dequeue together leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  // Next-state: a pending load miss waits for an empty buffer, otherwise writes drain in the background.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (load_miss && count == '0) state_nx = RD;
        else if (count != '0)         state_nx = WR;
      end
      WR:      if (bus_ack) state_nx = IDLE;
      RD:      if (bus_ack) state_nx = RD_DONE;
      RD_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered bus command: loaded on leaving IDLE and held until the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      bus_req <= (state_nx == WR) || (state_nx == RD);
      if (state_q == IDLE && state_nx == WR) begin
        bus_we    <= 1'b1;
        bus_addr  <= {wb_addr[rd_ptr], 2'b00};
        bus_wdata <= wb_data[rd_ptr];
      end else if (state_q == IDLE && state_nx == RD) begin
        bus_we   <= 1'b0;
        bus_addr <= {memaddr[31:2], 2'b00};
      end
    end
  end

  // Read-data register captures the bus word on the read ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       rd_data_q <= '0;
    else if (state_q == RD && bus_ack) rd_data_q <= bus_rdata;
  end

endmodule
